// File: rtl/cordic_gain_seq.sv
// cordic_gain_seq: sequential shift-add multiply of a signed 8-bit sample by
// the CORDIC gain K (GAIN in Q1.7, default 211/128 = 1.6484), one gain bit
// per clock, with valid/ready handshakes on both sides and symmetric
// saturation to +/-127.
// Optional feature macro: CORDIC_GAIN_ROUND_EN (round half up on the
// magnitude instead of truncating toward zero).
module cordic_gain_seq #(
  parameter logic [7:0] GAIN = 8'd211
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sat
);

  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

  state_t      state_q, state_d;
  logic        sign_q;
  logic [7:0]  mag_q;
  logic [15:0] acc_q;
  logic [3:0]  cnt_q;
  logic [7:0]  outData_q;
  logic        outSat_q;

  logic [15:0] addend;
  logic [15:0] accAdj;
  logic [15:0] shifted;
  logic        resSat;
  logic [7:0]  resMag;
  logic [7:0]  resData;
  logic [7:0]  inMag;

  // State register; reset aborts any in-flight sample back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: accept in IDLE, iterate 8 gain bits plus one result-load
  // cycle in MUL, wait for the downstream handshake in OUT.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = MUL;
      MUL:     if (cnt_q == 4'd8) state_d = OUT;
      OUT:     if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; in_ready is forced low while reset is held.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == OUT);
  end

  // Magnitude of the incoming sample; -128 maps to 128 in 8 unsigned bits.
  always_comb begin
    inMag = in_data[7] ? (~in_data + 8'd1) : in_data;
  end

  // Partial product for the current gain bit and the final scaled result.
  always_comb begin
    addend = {8'd0, mag_q} << cnt_q[2:0];
`ifdef CORDIC_GAIN_ROUND_EN
    accAdj = acc_q + 16'd64;
`else
    accAdj = acc_q;
`endif
    shifted = accAdj >> 7;
    resSat  = (shifted > 16'd127);
    resMag  = resSat ? 8'd127 : {1'b0, shifted[6:0]};
    resData = sign_q ? (~resMag + 8'd1) : resMag;
  end

  // Datapath: latch the sample, accumulate one gain bit per cycle, then
  // load the held output register when the eight iterations are done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q    <= 1'b0;
      mag_q     <= 8'd0;
      acc_q     <= 16'd0;
      cnt_q     <= 4'd0;
      outData_q <= 8'd0;
      outSat_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in_data[7];
            mag_q  <= inMag;
            acc_q  <= 16'd0;
            cnt_q  <= 4'd0;
          end
        end
        MUL: begin
          if (!cnt_q[3]) begin
            if (GAIN[cnt_q[2:0]]) acc_q <= acc_q + addend;
            cnt_q <= cnt_q + 4'd1;
          end else begin
            outData_q <= resData;
            outSat_q  <= resSat;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data = outData_q;
  assign out_sat  = outSat_q;

endmodule

// File: tb/tb_cordic_gain_seq.sv
// tb_cordic_gain_seq: directed bench for cordic_gain_seq with a behavioural
// gain model, hand-computed literal results and per-cycle output checking.
module tb_cordic_gain_seq;

  localparam int BENCH_GAIN = 211;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_sat;

  int   total = 0;
  int   bad   = 0;
  logic modelArmed = 1'b0;
  int   modelData = 0;
  int   modelSat  = 0;

  cordic_gain_seq #(.GAIN(8'(BENCH_GAIN))) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Gain model in plain integer arithmetic: |x| * K / 128, saturated.
  function automatic int modelOut(input int d, output int sat);
    int mag;
    int p;
    int r;
    mag = (d < 0) ? -d : d;
    p   = mag * BENCH_GAIN;
`ifdef CORDIC_GAIN_ROUND_EN
    p   = p + 64;
`endif
    r   = p / 128;
    sat = (r > 127) ? 1 : 0;
    if (r > 127) r = 127;
    return (d < 0) ? -r : r;
  endfunction

  // Whenever the result is presented it must match the model and be stable.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (!modelArmed) begin
        checkOutput("spuriousValid", 1, 0);
      end else begin
        checkOutput("modelData", int'($signed(out_data)), modelData);
        checkOutput("modelSat", int'(out_sat), modelSat);
        checkOutput("inReadyLowInOut", int'(in_ready), 0);
      end
    end
  end

  // One full transaction: accept, time the result, check, then hand off.
  task automatic applyStimulus(input int d, input int litData, input int litSat,
                               input int readyDelay, input bit toggle);
    int waited;
    int lat;
    int sat;
    waited = 0;
    lat    = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'(d);
    if (readyDelay == 0) out_ready = 1'b1;
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("acceptImmediate", waited, 0);
    modelData  = modelOut(d, sat);
    modelSat   = sat;
    modelArmed = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput("latency", lat, 9);
    checkOutput("litData", int'($signed(out_data)), litData);
    checkOutput("litSat", int'(out_sat), litSat);
    if (readyDelay > 0) begin
      for (int c = 0; c < readyDelay; c++) begin
        if (toggle) begin
          in_valid = ~in_valid;
          in_data  = 8'($urandom);
        end
        @(negedge clk);
        checkOutput("heldValid", int'(out_valid), 1);
        checkOutput("heldInReady", int'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    modelArmed = 1'b0;
    out_ready  = 1'b0;
    @(negedge clk);
    checkOutput("validDropped", int'(out_valid), 0);
    checkOutput("readyAfterHs", int'(in_ready), 1);
  endtask

  // Directed sequence: reset, nominal, saturation, rounding, edges,
  // backpressure and a reset abort in the middle of the multiply.
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("rstInReady", int'(in_ready), 0);
    checkOutput("rstOutValid", int'(out_valid), 0);
    checkOutput("rstOutData", int'(out_data), 0);
    checkOutput("rstOutSat", int'(out_sat), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idleInReady", int'(in_ready), 1);

    applyStimulus(50, 82, 0, 0, 1'b0);
    applyStimulus(-50, -82, 0, 2, 1'b0);
    applyStimulus(78, 127, 1, 1, 1'b0);
    applyStimulus(-128, -127, 1, 0, 1'b0);
    applyStimulus(127, 127, 1, 3, 1'b0);
`ifdef CORDIC_GAIN_ROUND_EN
    applyStimulus(77, 127, 0, 1, 1'b0);
    applyStimulus(3, 5, 0, 0, 1'b0);
    applyStimulus(1, 2, 0, 1, 1'b0);
    applyStimulus(-1, -2, 0, 0, 1'b0);
`else
    applyStimulus(77, 126, 0, 1, 1'b0);
    applyStimulus(3, 4, 0, 0, 1'b0);
    applyStimulus(1, 1, 0, 1, 1'b0);
    applyStimulus(-1, -1, 0, 0, 1'b0);
`endif
    applyStimulus(0, 0, 0, 1, 1'b0);

    applyStimulus(50, 82, 0, 20, 1'b1);
    applyStimulus(-50, -82, 0, 1, 1'b0);

    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'd50;
    checkOutput("abortAccept", int'(in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abortInReadyInRst", int'(in_ready), 0);
    checkOutput("abortValidInRst", int'(out_valid), 0);
    rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      checkOutput("abortNoValid", int'(out_valid), 0);
    end
    checkOutput("abortInReady", int'(in_ready), 1);
    checkOutput("abortOutData", int'(out_data), 0);
    checkOutput("abortOutSat", int'(out_sat), 0);

    applyStimulus(-50, -82, 0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
